// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Defining STALL_CNT_EN adds a saturating stall-cycle counter on the stall_count port.
module id_ex_stage #(
  parameter int CTRL_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_id,
  input  logic [31:0]       instr_id,
  input  logic [31:0]       pc4_id,
  input  logic [CTRL_W-1:0] ctrl_id,
  input  logic              flush,
  output logic [4:0]        RN1,
  output logic [4:0]        RN2,
  input  logic [31:0]       RD1,
  input  logic [31:0]       RD2,
  output logic              stall_o,
  output logic              valid_ex,
  output logic [CTRL_W-1:0] ctrl_ex,
  output logic [31:0]       pc4_ex,
  output logic [31:0]       rd1_ex,
  output logic [31:0]       rd2_ex,
  output logic [31:0]       imm_ex,
  output logic [4:0]        rs_ex,
  output logic [4:0]        rt_ex,
  output logic [4:0]        rd_ex
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]       stall_count
`endif
);
  logic hazard, capture, unused_opcode;
  assign RN1 = instr_id[25:21];
  assign RN2 = instr_id[20:16];
  assign hazard = valid_ex & ctrl_ex[4] & valid_id & (rt_ex != 5'd0) & ((rt_ex == RN1) | (rt_ex == RN2));
  assign stall_o = hazard & ~flush;
  assign capture = valid_id & ~flush & ~hazard;
  assign unused_opcode = ^instr_id[31:26];
  // Bubbles clear every field so a squashed slot is fully deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_ex <= 1'b0;
      ctrl_ex  <= '0;
      pc4_ex   <= '0;
      rd1_ex   <= '0;
      rd2_ex   <= '0;
      imm_ex   <= '0;
      rs_ex    <= '0;
      rt_ex    <= '0;
      rd_ex    <= '0;
    end else begin
      valid_ex <= capture;
      ctrl_ex  <= capture ? ctrl_id : '0;
      pc4_ex   <= capture ? pc4_id : '0;
      rd1_ex   <= capture ? RD1 : '0;
      rd2_ex   <= capture ? RD2 : '0;
      imm_ex   <= capture ? {{16{instr_id[15]}}, instr_id[15:0]} : '0;
      rs_ex    <= capture ? instr_id[25:21] : '0;
      rt_ex    <= capture ? instr_id[20:16] : '0;
      rd_ex    <= capture ? instr_id[15:11] : '0;
    end
  end
`ifdef STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_count <= '0;
    else if (stall_o && stall_count != 32'hFFFF_FFFF) stall_count <= stall_count + 32'd1;
  end
`endif
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the pipelined MIPS core. It drives the register-file read addresses from the IF/ID instruction and registers the returned operands, the sign-extended immediate, the register specifiers and the control word into the ID/EX pipeline register. It also contains the load-use hazard detector: it stalls IF/ID and inserts a bubble into EX. A branch flush also inserts a bubble.

## Interface
Parameters:
- CTRL_W, 9: control word width; bit map: [8] RegDst, [7] ALUSrc, [6] MemtoReg, [5] RegWrite, [4] MemRead, [3] MemWrite, [2] Branch, [1:0] ALUOp

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- valid_id  in  1  IF/ID holds a real instruction
- instr_id  in  32  IF/ID instruction word
- pc4_id  in  32  IF/ID PC+4
- ctrl_id  in  CTRL_W  control word from main decoder
- flush  in  1  branch taken in EX/MEM: squash ID instruction
- RN1  out  5  register-file read address 1 = instr_id[25:21] (combinational)
- RN2  out  5  register-file read address 2 = instr_id[20:16] (combinational)
- RD1  in  32  register-file read data 1
- RD2  in  32  register-file read data 2
- stall_o  out  1  load-use hazard: hold PC and IF/ID (combinational)
- valid_ex  out  1  EX holds a real instruction
- ctrl_ex  out  CTRL_W  registered control word
- pc4_ex  out  32  registered PC+4
- rd1_ex, rd2_ex  out  32  registered operands
- imm_ex  out  32  registered sign-extended instr[15:0]
- rs_ex, rt_ex, rd_ex  out  5  registered instr[25:21], [20:16], [15:11]
- stall_count  out  32  stall-cycle counter (only with STALL_CNT_EN)

## Operation
- Hazard: hazard = valid_ex & ctrl_ex[4] & valid_id & (rt_ex != 0) & ((rt_ex == RN1) | (rt_ex == RN2)).
- stall_o = hazard & ~flush. Flush overrides stall.
- Per posedge, priority order:
  1. flush: load bubble.
  2. stall_o: load bubble. IF/ID is held upstream, so the same instruction is re-read next cycle.
  3. valid_id = 0: load bubble.
  4. Otherwise capture all ID values; valid_ex = 1.
- Bubble: valid_ex = 0 and ctrl_ex = 0, so RegWrite, MemRead and MemWrite are all 0. Data/specifier registers may hold any value; they are cleared to 0 for determinism.
- Sign extension: imm_ex = {{16{instr_id[15]}}, instr_id[15:0]}.
- Register 0: the register file returns 0 for address 0. The stage passes RD1/RD2 unchanged and never raises a hazard on rt_ex == 0.
- No WB forwarding. The register file writes on the negedge, so a same-cycle WB write is visible on RD1/RD2 before the posedge capture.

## Timing
- Reset (rst_n low, asynchronous): every registered output is 0, valid_ex = 0 and stall_count = 0. stall_o evaluates to 0.
- Latency: one cycle from ID inputs to EX outputs.
- Load-use case: exactly one stall cycle. After the bubble enters EX, valid_ex = 0, so the hazard clears and the next posedge captures the held instruction.
- Reset mid-stall: state clears immediately and stall_o drops in the same cycle.
- flush together with a hazard: stall_o = 0, a bubble is loaded, and IF/ID is replaced upstream.
- RN1/RN2 follow instr_id combinationally. RD1/RD2 must settle within the same cycle.

## Configuration
- STALL_CNT_EN defined:
  - stall_count is present.
  - It increments on every posedge where stall_o = 1.
  - It saturates at 32'hFFFFFFFF and clears on reset.
- STALL_CNT_EN undefined: the stall_count port and counter logic are absent. All other behaviour is identical.

## Test plan
- Reset: drive rst_n low mid-cycle with valid_id = 1 -> all outputs 0 asynchronously and stall_o = 0. Release -> the first valid instruction captures on the next posedge.
- Pass-through: instr_id = 32'h8C22FFFC (lw $2,-4($1)), RD1 = 32'h1000, pc4_id = 32'h40 -> next cycle valid_ex = 1, RN1 = 1, rs_ex = 1, rt_ex = 2, imm_ex = 32'hFFFFFFFC, rd1_ex = 32'h1000, pc4_ex = 32'h40.
- Load-use: that lw is in EX and ID holds add $3,$2,$2 (32'h00421820) -> stall_o = 1 for one cycle and EX receives a bubble (ctrl_ex = 0). On the following cycle the add is captured and rd1_ex is the updated RD1.
- No false hazard: lw $0 in EX with add $3,$0,$0 in ID -> stall_o = 0. Also, a non-load (ctrl_ex[4] = 0) writing $2 with $2 used in ID -> stall_o = 0.
- Flush priority: hazard condition true and flush = 1 -> stall_o = 0 and the next cycle is a bubble (valid_ex = 0, ctrl_ex = 0).
- STALL_CNT_EN: three separate load-use events -> stall_count = 3. Preload the counter to 32'hFFFFFFFF via force, then one more event -> it remains 32'hFFFFFFFF.
